image_add_ctrl: RTL and testbench

- Sequencer for the two-source image-add datapath. Two single-port block RAMs, A and B, each hold 2**ADDR_W pixels.
- On `start`, the block walks every address, reads A and B, and forms a per-pixel sum (wrapping or saturating). It writes the sum to the result RAM at the same address, absorbing the RAM read latency.
- Reports completion, busy status and an overflow count. It replaces free-running address counters so that frames are processed on demand.

---
 rtl/image_add_ctrl_if.sv | 31 +++
 rtl/image_add_ctrl.sv | 97 +++++++++
 tb/tb_image_add_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/image_add_ctrl_if.sv
// rtl/image_add_ctrl_if.sv - control and RAM-side signal bundle for the image-add sequencer
interface image_add_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              start;
  logic              abort;
  logic              sat_en;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] b_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   ovf_cnt;

  // sequencer side
  modport slave (
    input  start, abort, sat_en, a_data, b_data,
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, ovf_cnt
  );

  // controller / RAM side
  modport master (
    output start, abort, sat_en, a_data, b_data,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, ovf_cnt
  );
endinterface

// File: rtl/image_add_ctrl.sv
// rtl/image_add_ctrl.sv - frame sequencer reading RAMs A/B and writing their per-pixel sum
module image_add_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input logic            clk,
  input logic            rst,
  image_add_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state;
  state_t            next_state;
  logic [1:0]        drain_cnt;
  logic              sat_q;
  logic              p_valid;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W:0]   sum;
  logic              flush;
  logic              accept;

  // abort only matters while a frame is in flight; it kills both pipeline stages
  assign flush  = bus.abort && (state == READ || state == DRAIN);
  assign accept = (state == IDLE) && bus.start && !bus.abort;
  // carry bit of the full-width sum marks overflow
  assign sum    = {1'b0, bus.a_data} + {1'b0, bus.b_data};

  // next-state: READ walks all addresses, DRAIN covers the two-stage pipeline plus one settle cycle
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (accept) next_state = READ;
      READ: begin
        if (bus.abort)         next_state = IDLE;
        else if (&bus.rd_addr) next_state = DRAIN;
      end
      DRAIN: begin
        if (bus.abort)              next_state = IDLE;
        else if (drain_cnt == 2'd2) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // state register and all registered outputs, derived from the next state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      drain_cnt   <= 2'd0;
      sat_q       <= 1'b0;
      p_valid     <= 1'b0;
      p_addr      <= '0;
      bus.rd_en   <= 1'b0;
      bus.rd_addr <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.ovf_cnt <= '0;
    end else begin
      state     <= next_state;
      drain_cnt <= (state == DRAIN && next_state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      bus.busy  <= (next_state == READ) || (next_state == DRAIN);
      bus.done  <= (next_state == DONE);
      bus.rd_en <= (next_state == READ);

      if (next_state == READ)
        bus.rd_addr <= (state == READ) ? bus.rd_addr + ADDR_W'(1) : '0;
      else
        bus.rd_addr <= '0;

      if (accept)
        sat_q <= bus.sat_en;

      // stage 1: the address whose data arrives next cycle
      p_valid <= bus.rd_en && !flush;
      p_addr  <= bus.rd_addr;

      // stage 2: register the sum alongside its address
      bus.wr_en <= p_valid && !flush;
      if (p_valid && !flush) begin
        bus.wr_addr <= p_addr;
        bus.wr_data <= (sat_q && sum[DATA_W]) ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
      end

      // count can reach N exactly, so the extra bit keeps it from wrapping
      if (accept)
        bus.ovf_cnt <= '0;
      else if (p_valid && !flush && sum[DATA_W])
        bus.ovf_cnt <= bus.ovf_cnt + (ADDR_W+1)'(1);
    end
  end

endmodule

// File: tb/tb_image_add_ctrl.sv
// tb/tb_image_add_ctrl.sv - scoreboard bench for image_add_ctrl
module tb_image_add_ctrl;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int N      = 64;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  image_add_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  image_add_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [DATA_W-1:0] mem_a [N];
  logic [DATA_W-1:0] mem_b [N];
  wr_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  f_cyc = 0;
  int  done_cnt = 0;
  int  busy_cnt = 0;
  int  when;

  // synchronous-read source RAMs
  always @(posedge clk) begin
    if (bus.rd_en === 1'b1) begin
      bus.a_data <= mem_a[bus.rd_addr];
      bus.b_data <= mem_b[bus.rd_addr];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every presented write is popped against the scoreboard
  always @(negedge clk) begin : mon
    wr_t e;
    if (bus.done === 1'b1) done_cnt++;
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.wr_en === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write actual addr=%0d data=%0d required none", bus.wr_addr, bus.wr_data);
      end else begin
        e = exp_q.pop_front();
        if (int'(bus.wr_addr) != e.addr || int'(bus.wr_data) != e.data) begin
          bad++;
          $display("FAIL write actual addr=%0d data=%0d required addr=%0d data=%0d",
                   bus.wr_addr, bus.wr_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input int addr, input int data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic fill(input int a, input int b);
    for (int k = 0; k < N; k++) begin
      mem_a[k] = DATA_W'(a);
      mem_b[k] = DATA_W'(b);
    end
  endtask

  task automatic pulse_start(input logic sat);
    busy_cnt = 0;
    done_cnt = 0;
    @(posedge clk);
    #1 bus.start = 1'b1;
    bus.sat_en = sat;
    @(posedge clk);
    #1 bus.start = 1'b0;
    f_cyc = cyc;
  endtask

  task automatic wait_done(output int t);
    t = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout actual=none required=pulse");
    end
  endtask

  task automatic finish_frame(input string tag, input int ovf);
    check({tag, "_len"}, when - f_cyc, N + 3);
    check({tag, "_busy_at_done"}, int'(bus.busy), 0);
    @(negedge clk);
    check({tag, "_done_width"}, int'(bus.done), 0);
    check({tag, "_busy_cycles"}, busy_cnt, N + 3);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_writes_left"}, exp_q.size(), 0);
    check({tag, "_ovf"}, int'(bus.ovf_cnt), ovf);
  endtask

  task automatic run_full(input string tag, input logic sat, input int ovf);
    pulse_start(sat);
    check({tag, "_rd_en_first"}, int'(bus.rd_en), 1);
    wait_done(when);
    finish_frame(tag, ovf);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_en"}, int'(bus.rd_en), 0);
    check({tag, "_wr_en"}, int'(bus.wr_en), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
  endtask

  int bnd_a[4] = '{255, 255, 128, 0};
  int bnd_b[4] = '{0, 1, 127, 0};
  int bnd_r[4] = '{255, 255, 255, 0};
  int tmo;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.sat_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check("reset_rd_addr", int'(bus.rd_addr), 0);
    check("reset_wr_data", int'(bus.wr_data), 0);
    check("reset_ovf", int'(bus.ovf_cnt), 0);
    rst = 1'b0;

    // basic modulo frame: A=k, B=2k, result 3k mod 256
    for (int k = 0; k < N; k++) begin
      mem_a[k] = DATA_W'(k);
      mem_b[k] = DATA_W'(2 * k);
      push(k, (3 * k) % 256);
    end
    run_full("basic", 1'b0, 0);

    // 200+100 wraps to 44
    fill(200, 100);
    for (int k = 0; k < N; k++) push(k, 44);
    run_full("wrap", 1'b0, 64);

    // same data saturates to 255
    for (int k = 0; k < N; k++) push(k, 255);
    run_full("sat", 1'b1, 64);

    // boundary sums; only 255+1 overflows
    for (int k = 0; k < N; k++) begin
      mem_a[k] = DATA_W'(bnd_a[k % 4]);
      mem_b[k] = DATA_W'(bnd_b[k % 4]);
      push(k, bnd_r[k % 4]);
    end
    run_full("bound", 1'b1, 16);

    // restart and sat_en toggle mid-frame are ignored
    fill(200, 100);
    for (int k = 0; k < N; k++) push(k, 44);
    pulse_start(1'b0);
    repeat (10) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.sat_en = 1'b1;
    wait_done(when);
    check("midstart_len", when - f_cyc, N + 3);
    // start coinciding with done is dropped
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("start_at_done_busy", int'(bus.busy), 0);
    check("start_at_done_rd_en", int'(bus.rd_en), 0);
    repeat (4) @(negedge clk);
    check("midstart_done_count", done_cnt, 1);
    check("midstart_writes_left", exp_q.size(), 0);
    check("midstart_ovf", int'(bus.ovf_cnt), 64);

    // start+abort in idle: abort wins, ovf_cnt untouched
    @(posedge clk);
    #1 bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.abort = 1'b0;
    check_idle_outputs("start_abort");
    check("start_abort_ovf_hold", int'(bus.ovf_cnt), 64);

    // abort sampled on the edge where rd_addr would advance to 20: writes 0..17 stand
    for (int k = 0; k < 18; k++) push(k, 44);
    bus.sat_en = 1'b0;
    pulse_start(1'b0);
    tmo = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.rd_addr == 19) begin
        tmo = 0;
        break;
      end
    end
    check("abort_reach_addr19", tmo, 0);
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    check_idle_outputs("abort");
    repeat (6) @(negedge clk);
    check("abort_done_count", done_cnt, 0);
    check("abort_writes_left", exp_q.size(), 0);
    check("abort_ovf", int'(bus.ovf_cnt), 18);

    // fresh frame after abort starts from address 0
    for (int k = 0; k < N; k++) push(k, 44);
    run_full("after_abort", 1'b0, 64);

    // reset mid-frame: writes 0..27 presented before reset takes effect
    for (int k = 0; k < N; k++) begin
      mem_a[k] = DATA_W'(k);
      mem_b[k] = DATA_W'(2 * k);
    end
    for (int k = 0; k < 28; k++) push(k, 3 * k);
    pulse_start(1'b0);
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_idle_outputs("midrst");
    check("midrst_rd_addr", int'(bus.rd_addr), 0);
    check("midrst_wr_addr", int'(bus.wr_addr), 0);
    check("midrst_ovf", int'(bus.ovf_cnt), 0);
    repeat (4) @(negedge clk);
    check("midrst_writes_left", exp_q.size(), 0);
    check("midrst_done_count", done_cnt, 0);

    for (int k = 0; k < N; k++) push(k, (3 * k) % 256);
    run_full("after_rst", 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
